// File: rtl/vecmem_pkg.sv
// Shared constants for the vector load/store memory sequencer: state codes,
// opcode values, store-mux selects and the lane decode helper.
package vecmem_pkg;

  localparam int LANES  = 4;
  localparam int BYTE_W = 8;

  localparam logic OP_VLD = 1'b0;
  localparam logic OP_VST = 1'b1;

  localparam logic [2:0] MEMIN_R1 = 3'd4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_XLAT  = 3'd1;
  localparam logic [2:0] S_STORE = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_LTAIL = 3'd4;
  localparam logic [2:0] S_WB    = 3'd5;

  function automatic logic [LANES-1:0] lane_onehot(input logic [1:0] lane);
    logic [LANES-1:0] vec;
    vec       = '0;
    vec[lane] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/vector_mem_sequencer.sv
// Four-beat VLD/VST sequencer that owns the byte-wide data memory while busy;
// all outputs are decoded from the registered state and lane index.
module vector_mem_sequencer
  import vecmem_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [BYTE_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [BYTE_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_wren,
  output logic [2:0]        mem_in_sel,
  output logic              vout_sel,
  output logic [LANES-1:0]  t_load,
  output logic              x_load,
  output logic              vrf_write
);

  logic [2:0]        state;
  logic [1:0]        idx;
  logic [BYTE_W-1:0] base;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= 2'd0;
      base  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            base  <= base_addr;
            idx   <= 2'd0;
            state <= (op == OP_VLD) ? S_LOAD : S_XLAT;
          end
        end
        S_LOAD: begin
          idx <= idx + 2'd1;
          if (idx == 2'd3) state <= S_LTAIL;
        end
        S_LTAIL: state <= S_WB;
        S_WB:    state <= S_IDLE;
        S_XLAT:  state <= S_STORE;
        S_STORE: begin
          idx <= idx + 2'd1;
          if (idx == 2'd3) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read data arrives one cycle after its address, so lane loads trail by one.
  always_comb begin
    busy       = (state != S_IDLE);
    done       = 1'b0;
    mem_addr   = '0;
    mem_read   = 1'b0;
    mem_wren   = 1'b0;
    mem_in_sel = MEMIN_R1;
    vout_sel   = 1'b0;
    t_load     = '0;
    x_load     = 1'b0;
    vrf_write  = 1'b0;
    case (state)
      S_LOAD: begin
        mem_addr = base + {{(BYTE_W-2){1'b0}}, idx};
        mem_read = 1'b1;
        vout_sel = 1'b1;
        if (idx != 2'd0) t_load = lane_onehot(idx - 2'd1);
      end
      S_LTAIL: begin
        vout_sel = 1'b1;
        t_load   = lane_onehot(2'd3);
      end
      S_WB: begin
        vrf_write = 1'b1;
        done      = 1'b1;
      end
      S_XLAT: x_load = 1'b1;
      S_STORE: begin
        mem_addr   = base + {{(BYTE_W-2){1'b0}}, idx};
        mem_wren   = 1'b1;
        mem_in_sel = {1'b0, 2'd3 - idx};
        done       = (idx == 2'd3);
      end
      default: ;
    endcase
  end

endmodule

// File: doc/vector_mem_sequencer.md
# vector_mem_sequencer

Multi-cycle sequencer for vector load (VLD) and vector store (VST) memory transfers in the multicycle processor. On a start request from the control FSM it takes over the byte-wide data memory for four consecutive beats, stepping the address from a base and steering the per-lane T registers (load) or the X1 byte-select mux (store). Loads finish with a VRF write strobe. The control FSM waits on `busy`/`done` instead of encoding one state per lane.

## Interface
Parameters: none; lane count (4) and byte width (8) are fixed package constants.

Ports:
- `clock`  in  1  system clock (KEY[1]-derived); all state updates on the rising edge
- `reset`  in  1  synchronous, active-high; returns the block to IDLE
- `start`  in  1  request pulse; sampled only in IDLE
- `op`  in  1  0 = VLD, 1 = VST; latched with `start`
- `base_addr`  in  8  first byte address; latched with `start`
- `busy`  out  1  high from the cycle after acceptance through the `done` cycle
- `done`  out  1  one-cycle pulse in the last busy cycle
- `mem_addr`  out  8  data-memory address
- `mem_read`  out  1  memory read enable
- `mem_wren`  out  1  memory write enable
- `mem_in_sel`  out  3  store-data mux select; 0..3 = X1[31:24], X1[23:16], X1[15:8], X1[7:0]; 4 = R1 (scalar path)
- `vout_sel`  out  1  T-register input select; 1 = memory q, 0 = lane adders
- `t_load`  out  4  one-hot T-lane load enable; bit k loads lane k (bits [8k+7:8k])
- `x_load`  out  1  X1/X2 capture strobe
- `vrf_write`  out  1  writes the T registers into VRF[IR[7:6]]

## Operation
- States: IDLE, XLAT, STORE, LOAD, LTAIL, WB. There is a 2-bit lane index `idx`.
- IDLE:
  - `start`=1 latches `op` and `base_addr` and clears `idx`.
  - Next state is LOAD if `op`=0, else XLAT.
  - `start` outside IDLE is ignored, with no queueing.
- Lane mapping: byte address base+k holds lane k.
  - Address arithmetic is 8-bit modulo 256. Base 0xFE gives 0xFE, 0xFF, 0x00, 0x01.
- LOAD (4 cycles, `idx`=0..3):
  - `mem_addr`=base+idx, `mem_read`=1, `vout_sel`=1.
  - `t_load`=onehot(idx-1) when idx>0; `t_load`=0 when idx=0.
  - `idx` increments each cycle. At idx=3 the next state is LTAIL.
- LTAIL (1 cycle): `t_load`=4'b1000, `vout_sel`=1, `mem_read`=0. Next state is WB.
- WB (1 cycle): `vrf_write`=1, `done`=1. Next state is IDLE.
- XLAT (1 cycle): `x_load`=1 to capture the source vector. Next state is STORE.
- STORE (4 cycles, `idx`=0..3):
  - `mem_addr`=base+idx, `mem_wren`=1, `mem_in_sel`=3-idx.
  - At idx=3: `done`=1, and the next state is IDLE.
- Default output values (reset and IDLE):
  - `busy`=0, `done`=0, `mem_addr`=0x00, `mem_read`=0, `mem_wren`=0.
  - `mem_in_sel`=3'd4, `vout_sel`=0, `t_load`=0, `x_load`=0, `vrf_write`=0.
- `mem_read` and `mem_wren` are never high in the same cycle.
- At most one `t_load` bit is high in any cycle.

## Timing
- All outputs are Moore, decoded from state and `idx`; there is no combinational path from `start`.
- Memory read latency is 1 cycle: q for address A is valid in the cycle after A is presented. This is why `t_load` lags the address by one cycle.
- VLD: `start` is accepted at edge E0.
  - Cycles 1–4: addresses issued.
  - Cycles 2–5: T lanes 0–3 loaded.
  - Cycle 6: `vrf_write` + `done`.
  - `busy` is high for cycles 1–6 (6 cycles).
- VST: `start` is accepted at E0.
  - Cycle 1: `x_load`.
  - Cycles 2–5: writes.
  - `done` is in cycle 5; `busy` is high for cycles 1–5 (5 cycles).
- Back-to-back: a new `start` can be accepted in the first IDLE cycle after `done`, so there is no dead cycle beyond that.
- Reset asserted in any state:
  - The next edge forces IDLE with default outputs.
  - No further `mem_wren`, `t_load` or `vrf_write` pulses occur.
  - Partially loaded T lanes keep their contents; the VRF is not written.
- `reset` and `start` high together: reset wins and `start` is dropped.

## Structure
- Shared package `vecmem_pkg`:
  - state encoding
  - `OP_VLD`=0, `OP_VST`=1
  - `MEMIN_R1`=3'd4
  - `LANES`=4
  - `BYTE_W`=8
- No sub-module. The lane counter and one-hot decode are inline.
- The instantiating top muxes the sequencer's `mem_addr`/`mem_read`/`mem_wren` against the FSM's AddrSel path using `busy`.

## Test plan
- VLD, base 0x10, memory 0x10..0x13 = 11,22,33,44:
  - `mem_addr` is 10,11,12,13 in cycles 1–4.
  - `t_load` is 0001..1000 in cycles 2–5.
  - T reads 0x44332211.
  - `vrf_write`+`done` in cycle 6.
- VST, X1 source 0xA1B2C3D4, base 0x20:
  - Writes 0xD4, 0xC3, 0xB2, 0xA1 to 0x20..0x23.
  - `mem_in_sel` goes 3,2,1,0.
  - `x_load` in cycle 1; `done` in cycle 5.
- Wrap-around: VLD at base 0xFE addresses FE, FF, 00, 01.
- `start` pulsed during the 3rd LOAD cycle is ignored. The transfer completes unchanged and `busy` returns low after exactly 6 cycles.
- `reset` asserted in the 2nd STORE cycle:
  - Only addresses 0x20 and 0x21 are written.
  - The next cycle shows all defaults (`mem_in_sel`=4, `mem_wren`=0).
- Back-to-back: VST then VLD with `start` high in the IDLE cycle right after `done`. The second op begins one cycle later, and no two transfers overlap.
